// File: rtl/calc_pkg.sv
// Shared definitions for the calculator job arbiter: the FSM state encoding
// and the default widths and timeout shared by the arbiter and its bench.
package calc_pkg;

  localparam int CALC_DATA_W      = 3;
  localparam int CALC_OP_W        = 2;
  localparam int CALC_TIMEOUT_CYC = 31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. Purely combinational: when both ports request,
// the port named by i_ptr wins; a lone requester always wins. The pointer
// register is owned by the parent so it can update it at job completion.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic [1:0] o_grant
);

  // Grant selection from request vector and favoured-port pointer.
  always_comb begin
    // NOTE: default first so every path assigns o_grant and no latch is inferred.
    o_grant = 2'b00;
    if (i_req == 2'b11) begin
      o_grant = i_ptr ? 2'b10 : 2'b01;
    end else begin
      o_grant = i_req;
    end
  end

endmodule

// File: rtl/calc_job_arbiter.sv
// Shares one Small_Calculator between two requesters. A job (op, two operands)
// is captured from the round-robin winner, issued with a one-cycle Calc_Go,
// and the calculator result is returned to that requester on Rsp_Valid.
// Optional macro CALC_TIMEOUT_EN: abandon a job after TIMEOUT_CYC WAIT cycles
// without Calc_Done and answer it with Rsp_Err=1, Rsp_Data=0.
module calc_job_arbiter
  import calc_pkg::*;
#(
  parameter int DATA_W      = CALC_DATA_W,
  parameter int OP_W        = CALC_OP_W,
  parameter int TIMEOUT_CYC = CALC_TIMEOUT_CYC
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [1:0]        Req,
  input  logic [OP_W-1:0]   Op0,
  input  logic [OP_W-1:0]   Op1,
  input  logic [DATA_W-1:0] A0,
  input  logic [DATA_W-1:0] B0,
  input  logic [DATA_W-1:0] A1,
  input  logic [DATA_W-1:0] B1,
  output logic [1:0]        Ack,
  output logic [1:0]        Rsp_Valid,
  output logic [DATA_W-1:0] Rsp_Data,
  output logic              Rsp_Err,
  output logic              Busy,
  output logic [7:0]        Jobs_Cnt,
  output logic              Calc_Go,
  output logic [OP_W-1:0]   Calc_Op,
  output logic [DATA_W-1:0] Calc_In1,
  output logic [DATA_W-1:0] Calc_In2,
  input  logic              Calc_Done,
  input  logic [DATA_W-1:0] Calc_Out
);

  state_t              r_state;
  logic                r_g;       // index of the port being served
  logic                r_ptr;     // favoured port for the next contention
  logic [1:0]          w_grant;
  logic [1:0]          r_ack;
  logic [1:0]          r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_busy;
  logic [7:0]          r_jobs_cnt;
  logic                r_calc_go;
  logic [OP_W-1:0]     r_calc_op;
  logic [DATA_W-1:0]   r_calc_in1;
  logic [DATA_W-1:0]   r_calc_in2;

  rr_arb2 u_arb (
    .i_req   (Req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

`ifdef CALC_TIMEOUT_EN
  localparam logic [4:0] TO_LAST = 5'(TIMEOUT_CYC - 1);
  logic [4:0] r_wait_cnt;
  logic       r_rsp_err;
`else
  // Timeout is compiled out; keep the parameter referenced for lint.
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYC == 0);
`endif

  // Job FSM: arbitration, issue, wait for Done, respond. All outputs registered.
  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: every output register is async-reset so a reset mid-job clears
    // the pins at once and silently drops the job in flight.
    if (!RST_N) begin
      r_state     <= IDLE;
      r_g         <= 1'b0;
      r_ptr       <= 1'b0;
      r_ack       <= 2'b00;
      r_rsp_valid <= 2'b00;
      r_rsp_data  <= '0;
      r_busy      <= 1'b0;
      r_jobs_cnt  <= 8'd0;
      r_calc_go   <= 1'b0;
      r_calc_op   <= '0;
      r_calc_in1  <= '0;
      r_calc_in2  <= '0;
`ifdef CALC_TIMEOUT_EN
      r_wait_cnt  <= 5'd0;
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      unique case (r_state)
        IDLE: begin
          if (|Req) begin
            r_g        <= w_grant[1];
            r_ack      <= w_grant;
            r_calc_go  <= 1'b1;
            r_calc_op  <= w_grant[1] ? Op1 : Op0;
            r_calc_in1 <= w_grant[1] ? A1  : A0;
            r_calc_in2 <= w_grant[1] ? B1  : B0;
            r_busy     <= 1'b1;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          r_ack     <= 2'b00;
          r_calc_go <= 1'b0;
`ifdef CALC_TIMEOUT_EN
          r_wait_cnt <= 5'd0;
`endif
          r_state   <= WAIT;
        end
        WAIT: begin
          if (Calc_Done) begin
            r_rsp_valid <= {r_g, ~r_g};
            r_rsp_data  <= Calc_Out;
            r_jobs_cnt  <= r_jobs_cnt + 8'd1;
            r_ptr       <= ~r_g;
            r_state     <= RESP;
          end
`ifdef CALC_TIMEOUT_EN
          else if (r_wait_cnt == TO_LAST) begin
            r_rsp_valid <= {r_g, ~r_g};
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b1;
            r_jobs_cnt  <= r_jobs_cnt + 8'd1;
            r_ptr       <= ~r_g;
            r_state     <= RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + 5'd1;
          end
`endif
        end
        RESP: begin
          r_rsp_valid <= 2'b00;
          r_rsp_data  <= '0;
          r_busy      <= 1'b0;
`ifdef CALC_TIMEOUT_EN
          r_rsp_err   <= 1'b0;
`endif
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Ack       = r_ack;
  assign Rsp_Valid = r_rsp_valid;
  assign Rsp_Data  = r_rsp_data;
  assign Busy      = r_busy;
  assign Jobs_Cnt  = r_jobs_cnt;
  assign Calc_Go   = r_calc_go;
  assign Calc_Op   = r_calc_op;
  assign Calc_In1  = r_calc_in1;
  assign Calc_In2  = r_calc_in2;
`ifdef CALC_TIMEOUT_EN
  assign Rsp_Err   = r_rsp_err;
`else
  assign Rsp_Err   = 1'b0;
`endif

endmodule

// File: tb/tb_calc_job_arbiter.sv
// Directed bench for calc_job_arbiter: a vector table of single jobs plus
// hand-written contention, spurious-Done, reset-in-WAIT, counter-wrap and
// (with CALC_TIMEOUT_EN) timeout sequences. The bench plays the calculator.
module tb_calc_job_arbiter;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [1:0] Req;
  logic [1:0] Op0, Op1;
  logic [2:0] A0, B0, A1, B1;
  logic [1:0] Ack, Rsp_Valid;
  logic [2:0] Rsp_Data;
  logic       Rsp_Err, Busy;
  logic [7:0] Jobs_Cnt;
  logic       Calc_Go;
  logic [1:0] Calc_Op;
  logic [2:0] Calc_In1, Calc_In2;
  logic       Calc_Done;
  logic [2:0] Calc_Out;

  int n_tests = 0;
  int n_fail  = 0;
  int go_cnt  = 0;
  bit go_en   = 1'b0;

  calc_job_arbiter dut (
    .CLK(CLK), .RST_N(RST_N), .Req(Req),
    .Op0(Op0), .Op1(Op1), .A0(A0), .B0(B0), .A1(A1), .B1(B1),
    .Ack(Ack), .Rsp_Valid(Rsp_Valid), .Rsp_Data(Rsp_Data), .Rsp_Err(Rsp_Err),
    .Busy(Busy), .Jobs_Cnt(Jobs_Cnt), .Calc_Go(Calc_Go), .Calc_Op(Calc_Op),
    .Calc_In1(Calc_In1), .Calc_In2(Calc_In2),
    .Calc_Done(Calc_Done), .Calc_Out(Calc_Out)
  );

  always #5 CLK = ~CLK;

  // Counts Calc_Go pulses while enabled; Go is high for one whole cycle.
  always @(negedge CLK) if (go_en && Calc_Go) go_cnt++;

  typedef struct {
    logic [1:0] req;
    logic [1:0] op0; logic [2:0] a0; logic [2:0] b0;
    logic [1:0] op1; logic [2:0] a1; logic [2:0] b1;
    int         delay;   // WAIT cycles before Done
    logic       spur;    // raise Done during ISSUE (must be ignored)
    logic [2:0] out;
    logic [1:0] e_ack;
    logic [1:0] e_op;
    logic [2:0] e_in1; logic [2:0] e_in2;
    logic [2:0] e_data;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_job(input vec_t v, input int idx);
    string s;
    s = $sformatf("v%0d", idx);
    @(negedge CLK);
    Req = v.req; Op0 = v.op0; A0 = v.a0; B0 = v.b0;
    Op1 = v.op1; A1 = v.a1; B1 = v.b1;
    @(negedge CLK);                         // ISSUE cycle
    check({s, "_ack"}, Ack, v.e_ack);
    check({s, "_go"}, Calc_Go, 1);
    check({s, "_busy"}, Busy, 1);
    check({s, "_op"}, Calc_Op, v.e_op);
    check({s, "_in1"}, Calc_In1, v.e_in1);
    check({s, "_in2"}, Calc_In2, v.e_in2);
    Req = 2'b00;
    Calc_Done = v.spur;
    @(negedge CLK);                         // first WAIT cycle
    Calc_Done = 1'b0;
    for (int i = 0; i < v.delay; i++) begin
      check({s, "_wait_go"}, Calc_Go, 0);
      check({s, "_wait_busy"}, Busy, 1);
      check({s, "_wait_rv"}, Rsp_Valid, 0);
      check({s, "_wait_ops"}, {Calc_Op, Calc_In1, Calc_In2}, {v.e_op, v.e_in1, v.e_in2});
      @(negedge CLK);
    end
    check({s, "_pre_rv"}, Rsp_Valid, 0);
    Calc_Done = 1'b1; Calc_Out = v.out;
    @(negedge CLK);                         // RESP cycle
    Calc_Done = 1'b0; Calc_Out = 3'd0;
    check({s, "_rv"}, Rsp_Valid, v.e_ack);
    check({s, "_data"}, Rsp_Data, v.e_data);
    check({s, "_err"}, Rsp_Err, 0);
    check({s, "_cnt"}, Jobs_Cnt, v.e_cnt);
    @(negedge CLK);                         // back in IDLE
    check({s, "_rv_pulse"}, Rsp_Valid, 0);
    check({s, "_idle_busy"}, Busy, 0);
  endtask

  // Minimal job on port 0 with Done in the first WAIT cycle.
  task automatic quick_job();
    @(negedge CLK); Req = 2'b01;
    @(negedge CLK); Req = 2'b00;
    @(negedge CLK); Calc_Done = 1'b1; Calc_Out = 3'd3;
    @(negedge CLK); Calc_Done = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    logic [1:0] exp_seq [4];
    bit got;
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;

    //           req    op0   a0 b0 op1   a1 b1 dly spur out  ack    op    in1 in2 data cnt
    vecs[0] = '{2'b01, 2'b00, 3, 2, 2'b00, 0, 0, 3, 0, 3'd5, 2'b01, 2'b00, 3, 2, 3'd5, 8'd1};
    vecs[1] = '{2'b10, 2'b00, 0, 0, 2'b01, 6, 1, 0, 0, 3'd5, 2'b10, 2'b01, 6, 1, 3'd5, 8'd2};
    vecs[2] = '{2'b01, 2'b10, 7, 7, 2'b00, 0, 0, 2, 1, 3'd1, 2'b01, 2'b10, 7, 7, 3'd1, 8'd3};
    // Port 0 served last, so port 1 is favoured under contention.
    vecs[3] = '{2'b11, 2'b01, 1, 1, 2'b11, 4, 5, 1, 0, 3'd7, 2'b10, 2'b11, 4, 5, 3'd7, 8'd4};
    vecs[4] = '{2'b11, 2'b01, 2, 6, 2'b10, 3, 3, 0, 0, 3'd0, 2'b01, 2'b01, 2, 6, 3'd0, 8'd5};
    // Stall: 20 WAIT cycles without Done.
    vecs[5] = '{2'b10, 2'b00, 0, 0, 2'b00, 5, 5, 20, 0, 3'd2, 2'b10, 2'b00, 5, 5, 3'd2, 8'd6};

    RST_N = 1'b0; Req = 2'b00; Op0 = '0; Op1 = '0; A0 = '0; B0 = '0; A1 = '0; B1 = '0;
    Calc_Done = 1'b0; Calc_Out = '0;
    repeat (2) @(negedge CLK);
    check("rst_outs", {Ack, Rsp_Valid, Rsp_Data, Rsp_Err, Busy, Jobs_Cnt, Calc_Go,
                       Calc_Op, Calc_In1, Calc_In2}, 0);
    RST_N = 1'b1;

    for (int i = 0; i < 6; i++) run_job(vecs[i], i);

    // Contention: Req=11 held for four jobs, grants alternate from port 0.
    go_cnt = 0; go_en = 1'b1;
    @(negedge CLK); Req = 2'b11;
    for (int j = 0; j < 4; j++) begin
      got = 1'b0;
      for (int t = 0; t < 6 && !got; t++) begin
        @(negedge CLK);
        if (Ack != 2'b00) got = 1'b1;
      end
      check($sformatf("rr_ack%0d", j), Ack, exp_seq[j]);
      if (j == 3) Req = 2'b00;
      @(negedge CLK); Calc_Done = 1'b1; Calc_Out = 3'(j);
      @(negedge CLK); Calc_Done = 1'b0;
      check($sformatf("rr_rv%0d", j), Rsp_Valid, exp_seq[j]);
      check($sformatf("rr_data%0d", j), Rsp_Data, j);
    end
    repeat (3) @(negedge CLK);
    go_en = 1'b0;
    check("rr_go_pulses", go_cnt, 4);
    check("rr_cnt", Jobs_Cnt, 10);

    // Spurious Done in IDLE.
    Calc_Done = 1'b1; Calc_Out = 3'd6;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("spur_rv", Rsp_Valid, 0);
      check("spur_busy", Busy, 0);
    end
    Calc_Done = 1'b0;
    @(negedge CLK);
    check("spur_cnt", Jobs_Cnt, 10);

    // Reset while in WAIT: outputs clear without a clock edge.
    Req = 2'b01; Op0 = 2'b11; A0 = 3'd6; B0 = 3'd5;
    @(negedge CLK); Req = 2'b00;
    check("rw_ack", Ack, 2'b01);
    @(negedge CLK);
    check("rw_in_wait", {Busy, Calc_Go}, 2'b10);
    #2 RST_N = 1'b0;
    #1 check("rw_async_outs", {Ack, Rsp_Valid, Rsp_Data, Rsp_Err, Busy, Jobs_Cnt, Calc_Go,
                               Calc_Op, Calc_In1, Calc_In2}, 0);
    @(negedge CLK); RST_N = 1'b1;
    @(negedge CLK);
    check("rw_no_rsp", Rsp_Valid, 0);
    Req = 2'b10; Op1 = 2'b01; A1 = 3'd2; B1 = 3'd4;
    @(negedge CLK); Req = 2'b00;
    check("rw_ack_p1", Ack, 2'b10);
    check("rw_in1_p1", Calc_In1, 3'd2);
    @(negedge CLK); Calc_Done = 1'b1; Calc_Out = 3'd4;
    @(negedge CLK); Calc_Done = 1'b0;
    check("rw_rv_p1", Rsp_Valid, 2'b10);
    check("rw_cnt", Jobs_Cnt, 1);
    @(negedge CLK);

    // Counter wrap: 255 more jobs take it from 1 back to 0.
    for (int i = 0; i < 255; i++) quick_job();
    check("cnt_wrap", Jobs_Cnt, 0);

`ifdef CALC_TIMEOUT_EN
    begin
      int n;
      n = 0;
      @(negedge CLK); Req = 2'b01; A0 = 3'd1; B0 = 3'd1;
      @(negedge CLK); Req = 2'b00;
      check("to_ack", Ack, 2'b01);
      for (int t = 0; t < 40 && Rsp_Valid == 2'b00; t++) begin
        @(negedge CLK);
        n++;
      end
      check("to_cycles", n, 32);
      check("to_rv", Rsp_Valid, 2'b01);
      check("to_err", Rsp_Err, 1);
      check("to_data", Rsp_Data, 0);
      check("to_cnt", Jobs_Cnt, 1);
      Calc_Done = 1'b1; Calc_Out = 3'd7;   // late Done in cycle 33
      @(negedge CLK); Calc_Done = 1'b0;
      check("to_late_rv", Rsp_Valid, 0);
      @(negedge CLK);
      check("to_late_rv2", Rsp_Valid, 0);
      check("to_late_cnt", Jobs_Cnt, 1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_job_arbiter.md
Name: calc_job_arbiter

Overview:
- Shares one Small_Calculator instance between two independent requesters (port 0, port 1).
- Accepts a job (Op, two 3-bit operands) from a requester and issues it to the calculator via Go.
- Waits for Done, then returns the captured Out to the winning requester.
- Round-robin arbitration; sits directly between requester logic and the calculator's Go/Op/In1/In2/Done/Out pins.

Parameters:
- DATA_W, 3, operand/result width (matches calculator In1/In2/Out)
- OP_W, 2, opcode width (matches calculator Op)
- TIMEOUT_CYC, 31, WAIT-state cycle limit (used only with CALC_TIMEOUT_EN)

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  reset, asynchronous assert, active-low
- Req  in  2  per-requester request level; hold until Ack
- Op0, Op1  in  OP_W  job opcode per requester
- A0, B0, A1, B1  in  DATA_W  job operands per requester
- Ack  out  2  one-cycle grant pulse, one-hot
- Rsp_Valid  out  2  one-cycle result pulse, one-hot
- Rsp_Data  out  DATA_W  result; valid only while Rsp_Valid != 0
- Rsp_Err  out  1  timeout flag, qualified by Rsp_Valid
- Busy  out  1  high whenever state != IDLE
- Jobs_Cnt  out  8  completed-job counter, wraps 255→0
- Calc_Go  out  1  calculator Go
- Calc_Op  out  OP_W  to calculator Op
- Calc_In1, Calc_In2  out  DATA_W  to calculator In1/In2
- Calc_Done  in  1  calculator Done
- Calc_Out  in  DATA_W  calculator Out

Behaviour:
- All outputs registered. Reset value of every output is 0; state=IDLE; RR pointer=0 (port 0 favoured). Reset mid-job abandons the job silently, with no Rsp_Valid.
- States:
  - IDLE: if any Req bit is set, the arbiter picks a winner → ISSUE.
    - Both requesting: the favoured port wins. Otherwise the single requester wins.
    - Winner's Op/A/B are captured into job registers; winner index g is latched.
  - ISSUE (1 cycle): Ack[g]=1, Calc_Go=1 → WAIT.
  - WAIT: Calc_Go=0. Calc_Op/In1/In2 are held stable from ISSUE through the end of WAIT. On the first cycle Calc_Done=1, Calc_Out is captured → RESP.
  - RESP (1 cycle): Rsp_Valid[g]=1, Rsp_Data=captured Out, Jobs_Cnt+1, RR pointer set to ~g → IDLE.
- Latency: Req sampled high in IDLE at edge k gives Ack and Calc_Go high in cycle k+1. Rsp_Valid is high one cycle after the cycle in which Done is sampled.
  - Minimum Req-to-Rsp_Valid time is 3 cycles when Done arrives in the first WAIT cycle.
- Requester rules:
  - Req must stay high, with operands stable, until Ack.
  - Req dropped before grant means no job.
  - Req still high after Ack is treated as a new job.
- A requester that loses arbitration is served next, so no starvation. With both held high, grants strictly alternate 0,1,0,1,…
- Calc_Done while in IDLE, ISSUE or RESP is ignored.
- Simultaneous Req with RESP: new requests are not sampled until IDLE. The RR pointer update takes effect for that arbitration.
- Jobs_Cnt counts timeout completions too; it wraps modulo 256.
- Calc_Out is passed through unmodified; arithmetic width is DATA_W with no extension.

Optional Feature:
- Macro: CALC_TIMEOUT_EN.
- Defined: a 5-bit WAIT counter clears on entry to WAIT.
  - If TIMEOUT_CYC cycles elapse in WAIT without Done → RESP with Rsp_Err=1, Rsp_Data=0.
  - A late Done is then ignored.
- Undefined: no counter; WAIT lasts until Done, indefinitely. Rsp_Err is tied 0.

Decomposition:
- Shared package calc_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP, 2-bit);
  - the DATA_W/OP_W defaults;
  - the TIMEOUT_CYC default.
- One sub-module, rr_arb2: 2-way round-robin picker, combinational grant from Req and pointer. The pointer register lives in the parent.

Test Plan:
- Single job: Req=01, Op0=2'b00, A0=3, B0=2; Done 4 cycles after Go, Calc_Out=5 → Ack=01 once, Calc_In1/In2=3/2 stable throughout WAIT, Rsp_Valid=01 for one cycle with Rsp_Data=5, Jobs_Cnt=1.
- Contention: Req=11 held for 4 jobs → Ack sequence 01,10,01,10; each Rsp_Valid matches its Ack; Calc_Go pulses exactly 4 times.
- Stall: Done held low for 20 cycles in WAIT → Calc_Go stays 0 after ISSUE, Busy=1, operands stable; then Done=1 → Rsp_Valid next cycle.
- Spurious Done: Calc_Done=1 while IDLE with Req=00 → no Rsp_Valid, Jobs_Cnt unchanged.
- Reset in WAIT: RST_N low mid-job → all outputs 0 immediately, without waiting for a clock edge; after release Req=10 → port 1 granted.
- CALC_TIMEOUT_EN defined, Done never asserted → Rsp_Valid with Rsp_Err=1, Rsp_Data=0 after 31 WAIT cycles; Done at cycle 33 is ignored.
